reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port successor to the CPU's 8x16 register file (`reg_file`).
- Provides 2 synchronous read ports and 2 write ports, with per-byte write enables.
- Parameter options: optional hard-wired zero register and optional write-to-read bypass.
- A per-register pending scoreboard lets the decode stage stall on results not yet written back.

Parameters:
- WIDTH, 16, register width in bits; must be a multiple of 8; NB = WIDTH/8 byte lanes.
- ADDR_W, 3, select width; DEPTH = 2**ADDR_W registers, so every select value is valid.
- BYPASS, 0, 0 = reads return pre-edge contents; 1 = reads return post-edge contents.
- R0_ZERO, 0, 1 = register 0 always reads 0, ignores writes and never goes pending.

Ports:
- I_clk  in  1  clock; all state updates on the rising edge.
- I_rst_n  in  1  synchronous active-low reset.
- I_en  in  1  global enable; when 0, no state or output changes.
- I_selA  in  ADDR_W  read port A select.
- I_selB  in  ADDR_W  read port B select.
- O_dataA  out  WIDTH  registered read data, port A.
- O_dataB  out  WIDTH  registered read data, port B.
- O_pendA  out  1  registered pending flag of register I_selA.
- O_pendB  out  1  registered pending flag of register I_selB.
- I_we0  in  1  write enable, port 0.
- I_selD0  in  ADDR_W  write select, port 0.
- I_dataD0  in  WIDTH  write data, port 0.
- I_be0  in  NB  byte enables, port 0 (bit i covers bits 8i+7:8i).
- I_we1  in  1  write enable, port 1.
- I_selD1  in  ADDR_W  write select, port 1.
- I_dataD1  in  WIDTH  write data, port 1.
- I_be1  in  NB  byte enables, port 1.
- I_lock  in  1  mark register I_selL pending.
- I_selL  in  ADDR_W  lock select.

Behaviour:
- One clock (I_clk); reset is synchronous and active-low (I_rst_n).
- Reset: I_rst_n=0 at a rising edge clears all registers, all pending bits, O_dataA/B and O_pendA/B to 0. Reset overrides I_en, writes and locks; a mid-operation reset discards in-flight writes.
- I_en=0: registers, pending bits and all outputs hold; we/lock inputs are ignored.
- Write, I_en=1:
  - Port p writes when I_we<p>=1; each lane i with I_be<p>[i]=1 takes I_dataD<p> lane i.
  - Lanes with be=0 keep their value. we=1 with be=0 changes nothing.
- Write collision (both ports, same select): per lane, port 1 wins where I_be1[i]=1; port 0 still writes lanes where only I_be0[i]=1.
- Read latency is 1 cycle. At an edge with I_en=1:
  - O_dataA <= reg[I_selA] and O_dataB <= reg[I_selB].
  - BYPASS=0: pre-edge value; a same-cycle write is visible on the next read.
  - BYPASS=1: merged post-edge value (both ports, lane-accurate).
- Pending scoreboard:
  - pend[I_selL] sets on I_en & I_lock.
  - pend[r] clears on I_en when any port writes r with a nonzero be.
  - Lock and clear of the same register in the same cycle: set wins.
  - O_pendA/B use the same pre-edge/post-edge rule as data, selected by BYPASS.
- Both read ports may select the same register; both get identical data.
- R0_ZERO=1: writes and locks to address 0 are dropped; a read of 0 returns 0 with pend 0.

Test Plan:
1. Reset: write r0=FFFF, then I_rst_n=0 for one edge -> O_dataA=0000, O_pendA=0; next read of r0 returns 0000.
2. Read latency and bypass: I_en=1, we0, selD0=2, data 2222, be=11, selA=2 in the same cycle.
   - BYPASS=0: O_dataA=0000 after that edge, 2222 after the next edge.
   - BYPASS=1: O_dataA=2222 after that edge.
3. Byte lanes: r4=4444, then we0 with be=01 and data ABCD -> r4 reads 44CD; be=00 with data 1234 -> r4 stays 44CD.
4. Collision: we0 sel3 data 1111 be=11 together with we1 sel3 data 2200 be=10 -> r3 reads 2211.
5. Enable and zero register:
   - I_en=0 with we0, sel0, data FEED -> r0 and outputs unchanged.
   - R0_ZERO=1 build: write 3333 to r0 -> reads 0000.
6. Scoreboard:
   - lock r5, selA=5 -> O_pendA=1.
   - we1 sel5 data 5555 -> O_pendA=0 and O_dataA=5555 (edge per BYPASS).
   - lock and write r5 in the same cycle -> O_pendA stays 1.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with 2 synchronous read ports,
// 2 byte-enabled write ports and a per-register pending scoreboard.
// Write port 1 wins per byte lane when both ports hit the same register.
// BYPASS selects pre-edge (0) or post-edge (1) read data and pending flags.
// R0_ZERO makes register 0 a constant zero that never goes pending.
module reg_file_mp #(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 3,
  parameter int BYPASS  = 0,
  parameter int R0_ZERO = 0
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  input  logic                I_en,
  input  logic [ADDR_W-1:0]   I_selA,
  input  logic [ADDR_W-1:0]   I_selB,
  output logic [WIDTH-1:0]    O_dataA,
  output logic [WIDTH-1:0]    O_dataB,
  output logic                O_pendA,
  output logic                O_pendB,
  input  logic                I_we0,
  input  logic [ADDR_W-1:0]   I_selD0,
  input  logic [WIDTH-1:0]    I_dataD0,
  input  logic [WIDTH/8-1:0]  I_be0,
  input  logic                I_we1,
  input  logic [ADDR_W-1:0]   I_selD1,
  input  logic [WIDTH-1:0]    I_dataD1,
  input  logic [WIDTH/8-1:0]  I_be1,
  input  logic                I_lock,
  input  logic [ADDR_W-1:0]   I_selL
);

  localparam int NB    = WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic [WIDTH-1:0] data_a_q;
  logic [WIDTH-1:0] data_a_d;
  logic [WIDTH-1:0] data_b_q;
  logic [WIDTH-1:0] data_b_d;
  logic             pend_a_q;
  logic             pend_a_d;
  logic             pend_b_q;
  logic             pend_b_d;

  // Merge both write ports lane by lane and update the pending scoreboard.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (I_en) begin
      for (int r = 0; r < DEPTH; r++) begin
        if ((R0_ZERO != 0) && (r == 0)) begin
          // Register 0 is hard-wired: drop writes and locks.
          regs_d[r] = {WIDTH{1'b0}};
          pend_d[r] = 1'b0;
        end else begin
          for (int i = 0; i < NB; i++) begin
            if (I_we1 && (I_selD1 == ADDR_W'(r)) && I_be1[i]) begin
              regs_d[r][8*i +: 8] = I_dataD1[8*i +: 8];
            end else if (I_we0 && (I_selD0 == ADDR_W'(r)) && I_be0[i]) begin
              regs_d[r][8*i +: 8] = I_dataD0[8*i +: 8];
            end else begin
              regs_d[r][8*i +: 8] = regs_q[r][8*i +: 8];
            end
          end
          // A lock in the same cycle as the write-back keeps the register pending.
          if (I_lock && (I_selL == ADDR_W'(r))) begin
            pend_d[r] = 1'b1;
          end else if ((I_we0 && (I_selD0 == ADDR_W'(r)) && (|I_be0)) ||
                       (I_we1 && (I_selD1 == ADDR_W'(r)) && (|I_be1))) begin
            pend_d[r] = 1'b0;
          end else begin
            pend_d[r] = pend_q[r];
          end
        end
      end
    end else begin
      regs_d = regs_q;
      pend_d = pend_q;
    end
  end

  // Select read data and pending flags from pre-edge or post-edge state.
  always_comb begin
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    pend_a_d = pend_a_q;
    pend_b_d = pend_b_q;
    if (I_en) begin
      if (BYPASS != 0) begin
        data_a_d = regs_d[I_selA];
        data_b_d = regs_d[I_selB];
        pend_a_d = pend_d[I_selA];
        pend_b_d = pend_d[I_selB];
      end else begin
        data_a_d = regs_q[I_selA];
        data_b_d = regs_q[I_selB];
        pend_a_d = pend_q[I_selA];
        pend_b_d = pend_q[I_selB];
      end
    end else begin
      data_a_d = data_a_q;
      data_b_d = data_b_q;
      pend_a_d = pend_a_q;
      pend_b_d = pend_b_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= {WIDTH{1'b0}};
      end
      pend_q   <= {DEPTH{1'b0}};
      data_a_q <= {WIDTH{1'b0}};
      data_b_q <= {WIDTH{1'b0}};
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      pend_q   <= pend_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
    end
  end

  assign O_dataA = data_a_q;
  assign O_dataB = data_b_q;
  assign O_pendA = pend_a_q;
  assign O_pendB = pend_b_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (BYPASS=0/R0_ZERO=0 and
// BYPASS=1/R0_ZERO=1) share one stimulus stream and are compared every
// cycle against an array-based model, plus directed literal checks.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst_n, en, we0, we1, lock;
  logic [2:0]  selA, selB, selD0, selD1, selL;
  logic [15:0] dD0, dD1;
  logic [1:0]  be0, be1;

  logic [15:0] da0, db0, da1, db1;
  logic        pa0, pb0, pa1, pb1;

  int tests = 0;
  int fails = 0;

  // Model state per instance k: register contents and pending bits.
  logic [15:0] mm [2][8];
  logic [7:0]  mp [2];
  logic [15:0] ea [2];
  logic [15:0] eb [2];
  logic        epa [2];
  logic        epb [2];
  bit          byp [2] = '{1'b0, 1'b1};
  bit          r0z [2] = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  reg_file_mp #(.WIDTH(16), .ADDR_W(3), .BYPASS(0), .R0_ZERO(0)) u0 (
    .I_clk(clk), .I_rst_n(rst_n), .I_en(en),
    .I_selA(selA), .I_selB(selB),
    .O_dataA(da0), .O_dataB(db0), .O_pendA(pa0), .O_pendB(pb0),
    .I_we0(we0), .I_selD0(selD0), .I_dataD0(dD0), .I_be0(be0),
    .I_we1(we1), .I_selD1(selD1), .I_dataD1(dD1), .I_be1(be1),
    .I_lock(lock), .I_selL(selL)
  );

  reg_file_mp #(.WIDTH(16), .ADDR_W(3), .BYPASS(1), .R0_ZERO(1)) u1 (
    .I_clk(clk), .I_rst_n(rst_n), .I_en(en),
    .I_selA(selA), .I_selB(selB),
    .O_dataA(da1), .O_dataB(db1), .O_pendA(pa1), .O_pendB(pb1),
    .I_we0(we0), .I_selD0(selD0), .I_dataD0(dD0), .I_be0(be0),
    .I_we1(we1), .I_selD1(selD1), .I_dataD1(dD1), .I_be1(be1),
    .I_lock(lock), .I_selL(selL)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock: update the model from the inputs seen at the edge,
  // then compare every output of both instances against it.
  task automatic step();
    logic [15:0] nm [8];
    logic [7:0]  np;
    logic [15:0] m0, m1;
    @(posedge clk);
    m0 = {{8{be0[1]}}, {8{be0[0]}}};
    m1 = {{8{be1[1]}}, {8{be1[0]}}};
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int r = 0; r < 8; r++) mm[k][r] = 16'h0000;
        mp[k] = 8'h00;
        ea[k] = 16'h0000; eb[k] = 16'h0000;
        epa[k] = 1'b0;    epb[k] = 1'b0;
      end else if (en) begin
        for (int r = 0; r < 8; r++) nm[r] = mm[k][r];
        np = mp[k];
        if (we0) nm[selD0] = (nm[selD0] & ~m0) | (dD0 & m0);
        if (we1) nm[selD1] = (nm[selD1] & ~m1) | (dD1 & m1);
        if (we0 && be0 != 2'b00) np[selD0] = 1'b0;
        if (we1 && be1 != 2'b00) np[selD1] = 1'b0;
        if (lock) np[selL] = 1'b1;
        if (r0z[k]) begin
          nm[0] = 16'h0000;
          np[0] = 1'b0;
        end
        if (byp[k]) begin
          ea[k] = nm[selA]; eb[k] = nm[selB];
          epa[k] = np[selA]; epb[k] = np[selB];
        end else begin
          ea[k] = mm[k][selA]; eb[k] = mm[k][selB];
          epa[k] = mp[k][selA]; epb[k] = mp[k][selB];
        end
        for (int r = 0; r < 8; r++) mm[k][r] = nm[r];
        mp[k] = np;
      end
    end
    #1;
    check("u0_dataA", da0, ea[0]);
    check("u0_dataB", db0, eb[0]);
    check("u0_pendA", {15'd0, pa0}, {15'd0, epa[0]});
    check("u0_pendB", {15'd0, pb0}, {15'd0, epb[0]});
    check("u1_dataA", da1, ea[1]);
    check("u1_dataB", db1, eb[1]);
    check("u1_pendA", {15'd0, pa1}, {15'd0, epa[1]});
    check("u1_pendB", {15'd0, pb1}, {15'd0, epb[1]});
  endtask

  task automatic idle();
    rst_n = 1'b1; en = 1'b1; we0 = 1'b0; we1 = 1'b0; lock = 1'b0;
    be0 = 2'b00; be1 = 2'b00; dD0 = 16'h0000; dD1 = 16'h0000;
    selD0 = 3'd0; selD1 = 3'd0; selL = 3'd0;
  endtask

  task automatic wr0(input logic [2:0] s, input logic [15:0] d, input logic [1:0] b);
    we0 = 1'b1; selD0 = s; dD0 = d; be0 = b;
  endtask

  initial begin
    idle();
    selA = 3'd0; selB = 3'd0;
    rst_n = 1'b0;
    step();
    step();
    check("reset_dataA", da0, 16'h0000);
    check("reset_pendA", {15'd0, pa0}, 16'h0000);

    // 1. Reset clears registers and outputs.
    idle(); wr0(3'd0, 16'hFFFF, 2'b11); selA = 3'd0;
    step();
    idle();
    step();
    check("t1_r0_written", da0, 16'hFFFF);
    rst_n = 1'b0;
    step();
    check("t1_reset_out", da0, 16'h0000);
    idle();
    step();
    check("t1_r0_after_reset", da0, 16'h0000);

    // 2. Read latency versus bypass.
    idle(); wr0(3'd2, 16'h2222, 2'b11); selA = 3'd2;
    step();
    check("t2_nobyp_first", da0, 16'h0000);
    check("t2_byp_first", da1, 16'h2222);
    idle();
    step();
    check("t2_nobyp_second", da0, 16'h2222);

    // 3. Byte lanes.
    idle(); wr0(3'd4, 16'h4444, 2'b11);
    step();
    idle(); wr0(3'd4, 16'hABCD, 2'b01);
    step();
    idle(); wr0(3'd4, 16'h1234, 2'b00);
    step();
    idle(); selA = 3'd4;
    step();
    check("t3_lanes_u0", da0, 16'h44CD);
    check("t3_lanes_u1", da1, 16'h44CD);
    check("t3_model", ea[0], 16'h44CD);

    // 4. Write collision on one register.
    idle(); wr0(3'd3, 16'h1111, 2'b11);
    we1 = 1'b1; selD1 = 3'd3; dD1 = 16'h2200; be1 = 2'b10;
    step();
    idle(); selA = 3'd3; selB = 3'd3;
    step();
    check("t4_collide_u0", da0, 16'h2211);
    check("t4_collide_u1", da1, 16'h2211);
    check("t4_sameB", db0, 16'h2211);
    check("t4_model", ea[1], 16'h2211);

    // 5. Enable low holds everything; zero register.
    idle(); en = 1'b0; wr0(3'd0, 16'hFEED, 2'b11); selA = 3'd0;
    step();
    check("t5_en0_hold", da0, 16'h2211);
    idle(); selA = 3'd0;
    step();
    check("t5_r0_unchanged", da0, 16'h0000);
    idle(); wr0(3'd0, 16'h3333, 2'b11);
    step();
    idle();
    step();
    check("t5_r0_normal", da0, 16'h3333);
    check("t5_r0_zero", da1, 16'h0000);

    // 6. Pending scoreboard.
    idle(); lock = 1'b1; selL = 3'd5; selA = 3'd5;
    step();
    check("t6_lock_byp", {15'd0, pa1}, 16'h0001);
    check("t6_lock_nobyp_pre", {15'd0, pa0}, 16'h0000);
    idle();
    step();
    check("t6_lock_nobyp", {15'd0, pa0}, 16'h0001);
    idle(); we1 = 1'b1; selD1 = 3'd5; dD1 = 16'h5555; be1 = 2'b11;
    step();
    check("t6_clear_byp_p", {15'd0, pa1}, 16'h0000);
    check("t6_clear_byp_d", da1, 16'h5555);
    check("t6_clear_nobyp_pre", {15'd0, pa0}, 16'h0001);
    idle();
    step();
    check("t6_clear_nobyp_p", {15'd0, pa0}, 16'h0000);
    check("t6_clear_nobyp_d", da0, 16'h5555);
    idle(); lock = 1'b1; selL = 3'd5;
    we1 = 1'b1; selD1 = 3'd5; dD1 = 16'h0505; be1 = 2'b11;
    step();
    idle();
    step();
    check("t6_set_wins_u0", {15'd0, pa0}, 16'h0001);
    check("t6_set_wins_u1", {15'd0, pa1}, 16'h0001);

    // Randomized traffic checked every cycle by step().
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      en    = ($urandom_range(0, 9) != 0);
      we0   = $urandom_range(0, 1);
      we1   = $urandom_range(0, 1);
      lock  = ($urandom_range(0, 3) == 0);
      selA  = 3'($urandom_range(0, 7));
      selB  = 3'($urandom_range(0, 7));
      selD0 = 3'($urandom_range(0, 7));
      selD1 = ($urandom_range(0, 3) == 0) ? selD0 : 3'($urandom_range(0, 7));
      selL  = 3'($urandom_range(0, 7));
      dD0   = 16'($urandom);
      dD1   = 16'($urandom);
      be0   = 2'($urandom_range(0, 3));
      be1   = 2'($urandom_range(0, 3));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
